// File: rtl/pcie_tlp_pkg.sv
// Shared TLP-path types and helpers.
// Holds the arbiter state encoding and the round-robin winner search.
package pcie_tlp_pkg;

  localparam int unsigned RR_MAX_PORTS = 8;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } arb_state_t;

  // Unused request bits must be zero. A search modulo 8 then lands on the
  // same winner as a search modulo the real port count.
  function automatic logic [2:0] rr_next(input logic [7:0] req, input logic [2:0] ptr);
    logic [2:0] idx;
    logic [2:0] win;
    logic       found;
    win   = 3'd0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end else begin
        win   = win;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/pcie_cpl_arbiter_if.sv
// Completion-source side and merged completion side of the arbiter.
// "slave" is the arbiter view; "master" is the view of the surrounding sources and sink.
interface pcie_cpl_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1,
  parameter int NUM_PORTS  = 2
);
  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_PORTS*KEEP_WIDTH-1:0] s_axis_tkeep;
  logic [NUM_PORTS-1:0]            s_axis_tvalid;
  logic [NUM_PORTS-1:0]            s_axis_tlast;
  logic [NUM_PORTS*USER_WIDTH-1:0] s_axis_tuser;
  logic [NUM_PORTS-1:0]            s_axis_tready;
  logic [DATA_WIDTH-1:0]           cpl_axis_tdata;
  logic [KEEP_WIDTH-1:0]           cpl_axis_tkeep;
  logic                            cpl_axis_tvalid;
  logic                            cpl_axis_tlast;
  logic [USER_WIDTH-1:0]           cpl_axis_tuser;
  logic                            cpl_axis_tready;

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    output cpl_axis_tready,
    input  s_axis_tready,
    input  cpl_axis_tdata, cpl_axis_tkeep, cpl_axis_tvalid, cpl_axis_tlast, cpl_axis_tuser
  );

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    input  cpl_axis_tready,
    output s_axis_tready,
    output cpl_axis_tdata, cpl_axis_tkeep, cpl_axis_tvalid, cpl_axis_tlast, cpl_axis_tuser
  );
endinterface

// File: rtl/pcie_rr_arbiter.sv
// Combinational round-robin pick: the first requester at or after ptr_i, with wrap.
// This block can be reused by the TLP request arbiter.
module pcie_rr_arbiter
  import pcie_tlp_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int SEL_WIDTH = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [SEL_WIDTH-1:0] ptr_i,
  output logic [SEL_WIDTH-1:0] grant_o,
  output logic                 valid_o
);

  assign grant_o = SEL_WIDTH'(rr_next(8'(req_i), 3'(ptr_i)));
  assign valid_o = |req_i;

endmodule

// File: rtl/pcie_cpl_arbiter.sv
// Packet-atomic round-robin merge of completion AXIS sources onto one stream.
// The grant is held from the first beat until the tlast beat is accepted.
module pcie_cpl_arbiter
  import pcie_tlp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1,
  parameter int NUM_PORTS  = 2,
  parameter int SEL_WIDTH  = $clog2(NUM_PORTS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  pcie_cpl_arbiter_if.slave    bus,
  output logic [SEL_WIDTH-1:0] grant_idx_o,
  output logic                 busy_o
);

  arb_state_t           state_q, state_d;
  logic [SEL_WIDTH-1:0] grant_q, grant_d;
  logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [SEL_WIDTH-1:0] win_idx;
  logic                 req_any;
  logic                 active;
  logic                 xfer_last;

  pcie_rr_arbiter #(
    .NUM_PORTS(NUM_PORTS),
    .SEL_WIDTH(SEL_WIDTH)
  ) u_rr (
    .req_i  (bus.s_axis_tvalid),
    .ptr_i  (rr_ptr_q),
    .grant_o(win_idx),
    .valid_o(req_any)
  );

  assign active    = (state_q == ST_ACTIVE);
  assign xfer_last = bus.cpl_axis_tvalid & bus.cpl_axis_tready & bus.cpl_axis_tlast;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          grant_d = win_idx;
          state_d = ST_ACTIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        // A stalled or missing beat mid-packet keeps the grant indefinitely.
        if (xfer_last) begin
          rr_ptr_d = (grant_q == SEL_WIDTH'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d  = ST_ACTIVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.cpl_axis_tdata  = bus.s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    bus.cpl_axis_tkeep  = bus.s_axis_tkeep[int'(grant_q)*KEEP_WIDTH +: KEEP_WIDTH];
    bus.cpl_axis_tuser  = bus.s_axis_tuser[int'(grant_q)*USER_WIDTH +: USER_WIDTH];
    bus.cpl_axis_tlast  = bus.s_axis_tlast[grant_q];
    bus.cpl_axis_tvalid = active & bus.s_axis_tvalid[grant_q];
    bus.s_axis_tready   = '0;
    if (active) begin
      bus.s_axis_tready[grant_q] = bus.cpl_axis_tready;
    end else begin
      bus.s_axis_tready = '0;
    end
  end

  assign busy_o      = active;
  assign grant_idx_o = grant_q;

endmodule

// File: doc/pcie_cpl_arbiter.md
# pcie_cpl_arbiter

Packet-atomic round-robin arbiter that shares the single completion AXI-Stream path toward the DMA/transmit side between several completion sources: the config handler, a memory-request handler and future function blocks. Each source presents whole completion TLPs as 32-bit AXIS beats. The arbiter grants one source at a time and holds the grant until that packet's `tlast` beat is accepted. It sits between the per-function completion generators and the TLP transmit path.

## Interface
Parameters:
- `DATA_WIDTH`, 32 — beat width in bits.
- `KEEP_WIDTH`, `DATA_WIDTH/8` — `tkeep` width.
- `USER_WIDTH`, 1 — `tuser` width.
- `NUM_PORTS`, 2 — number of completion sources; legal range 2..8.
- `SEL_WIDTH`, `$clog2(NUM_PORTS)` — grant index width.

Ports:
- `clk_i` input 1 — single clock.
- `rst_i` input 1 — reset, asynchronous, active-high.
- `s_axis_tdata` input `NUM_PORTS*DATA_WIDTH` — per-source data; port i occupies slice `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `s_axis_tkeep` input `NUM_PORTS*KEEP_WIDTH` — per-source keep.
- `s_axis_tvalid` input `NUM_PORTS` — per-source valid.
- `s_axis_tlast` input `NUM_PORTS` — per-source last.
- `s_axis_tuser` input `NUM_PORTS*USER_WIDTH` — per-source user.
- `s_axis_tready` output `NUM_PORTS` — per-source ready.
- `cpl_axis_tdata` output `DATA_WIDTH` — merged completion data.
- `cpl_axis_tkeep` output `KEEP_WIDTH` — merged keep.
- `cpl_axis_tvalid` output 1 — merged valid.
- `cpl_axis_tlast` output 1 — merged last.
- `cpl_axis_tuser` output `USER_WIDTH` — merged user.
- `cpl_axis_tready` input 1 — downstream ready.
- `grant_idx_o` output `SEL_WIDTH` — index of the currently or last granted source.
- `busy_o` output 1 — high while a packet is in flight.

## Operation
States:
- `ST_IDLE`: no grant.
  - All `s_axis_tready`=0 and `cpl_axis_tvalid`=0.
  - If any `s_axis_tvalid` is set, pick the winner by round-robin: the first requesting port found at or after `rr_ptr`, searching upward with wrap modulo `NUM_PORTS`.
  - Register the winner into `grant`, then go to `ST_ACTIVE`.
  - If no port requests, stay in `ST_IDLE`.
- `ST_ACTIVE`: the granted port is connected combinationally to the output.
  - `cpl_axis_*` = `s_axis_*[grant]`.
  - `s_axis_tready[grant]` = `cpl_axis_tready`; every other ready bit is 0.
  - A beat transfers when `cpl_axis_tvalid & cpl_axis_tready`.
  - When a transferred beat has `tlast`=1: set `rr_ptr` = `grant`+1 (wrapping to 0 after `NUM_PORTS-1`) and return to `ST_IDLE`.
  - The grant is never revoked mid-packet. If the granted source drops `tvalid` mid-packet, the arbiter waits in `ST_ACTIVE` indefinitely.
- Outputs:
  - `busy_o` = (state == `ST_ACTIVE`).
  - `grant_idx_o` = `grant` register; it holds its value in `ST_IDLE`.
- Requests that appear while a packet is in flight are only considered at the next `ST_IDLE` evaluation.
- A single-beat packet (`tlast` on the first beat) is legal and is handled identically to a multi-beat packet.

## Timing
- Reset values (asynchronous assert; release is synchronized externally):
  - state = `ST_IDLE`, `grant`=0, `rr_ptr`=0.
  - Hence `cpl_axis_tvalid`=0, all `s_axis_tready`=0, `busy_o`=0, `grant_idx_o`=0.
- Reset asserted mid-packet: the packet is abandoned and no further beats are forwarded. Downstream framing recovery is the transmit path's responsibility.
- Latency:
  - The first beat reaches the output 1 cycle after `tvalid` is seen in `ST_IDLE`.
  - After that, beats pass with zero cycles of latency at full throughput.
- One idle bubble cycle separates back-to-back packets, so sustained utilization for packets of N beats is N/(N+1). This is acceptable for the completion rate.
- AXIS rules:
  - Data and control must stay stable while `tvalid` is high and `tready` is low; this holds on both sides.
  - The arbiter never asserts `s_axis_tready` to a port that is not granted.

## Structure
- Add `arb_state_t` (`ST_IDLE`, `ST_ACTIVE`) to `pcie_tlp_pkg`.
- Add a `rr_next(req, ptr)` function to `pcie_tlp_pkg` that returns the winner index.
- Natural sub-module: `pcie_rr_arbiter`, a combinational round-robin pick from `req` and `rr_ptr`, reusable by the future TLP request arbiter.
- Output muxing and the FSM live in the top module. No skid buffer: each source is expected to drive from its own `axis_register`.

## Test plan
- Single source: port 0 sends 3 beats `0x4A000001`, `0x00000100`, `0xDEADBEEF` (`tlast` on beat 3) with `cpl_axis_tready`=1.
  - Output shows these 3 beats on cycles 1-3 after `tvalid`.
  - `grant_idx_o`=0; `rr_ptr` becomes 1.
- Contention: ports 0 and 1 both request from reset.
  - Port 0 is served first, then port 1 after a 1-cycle bubble.
  - A third packet from port 0 is served after port 1.
- Mid-packet request: port 1 raises `tvalid` during beat 2 of a 4-beat packet on port 0.
  - `s_axis_tready[1]` stays 0 until port 0's `tlast` transfers.
  - No interleaving appears on the output.
- Backpressure: `cpl_axis_tready` toggles 1,0,0,1 during a 3-beat packet.
  - Output data stays stable while stalled.
  - Exactly 3 beats transfer and the order is preserved.
- Wrap: with `NUM_PORTS`=3 and `rr_ptr`=2, ports 0 and 2 request.
  - Port 2 wins, `rr_ptr` wraps to 0, and port 0 is served next.
- Reset mid-packet: assert `rst_i` asynchronously during beat 2 of a 3-beat packet.
  - `cpl_axis_tvalid`, `s_axis_tready` and `busy_o` drop to 0 immediately, without waiting for a clock edge.
  - After release, the next packet is granted from port 0.
